nanorv32_ram_arbiter: RTL and testbench

- Shares one single-port, byte-write 32-bit RAM between two requesters: the instruction-fetch port (read-only) and the data load/store port (read/write with byte enables).
- Sits between the nanorv32 core bus ports and the RAM macro.
- Resolves conflicts with a round-robin arbiter, drives the RAM control signals, and returns read data one cycle after grant.

---
 rtl/nanorv32_ram_arbiter_pkg.sv | 11 +
 rtl/nanorv32_ram_arbiter_rr_arb2.sv | 58 +++++
 rtl/nanorv32_ram_arbiter.sv | 75 +++++++
 tb/tb_nanorv32_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nanorv32_ram_arbiter_pkg.sv
// Shared widths and port indices for the nanorv32 RAM arbiter.
package nanorv32_ram_arb_pkg;

  localparam int COL_WIDTH  = 8;
  localparam int NB_COL     = 4;
  localparam int DATA_WIDTH = COL_WIDTH * NB_COL;

  localparam logic IPORT = 1'b0;
  localparam logic DPORT = 1'b1;

endpackage

// File: rtl/nanorv32_ram_arbiter_rr_arb2.sv
// Two-way arbiter: round-robin by default, DPORT priority with IPORT starvation
// guard when NANORV32_RAM_ARB_DPRIO_EN is defined.
module nanorv32_rr_arb2
  import nanorv32_ram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic i_first;

`ifdef NANORV32_RAM_ARB_DPRIO_EN
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_cnt;

  always_comb i_first = (starve_cnt >= CNT_W'(STARVE_MAX));

  // Counts IPORT conflict losses; saturates so a long stall cannot wrap back to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (gnt[IPORT]) begin
      starve_cnt <= '0;
    end else if (req[IPORT] && (starve_cnt < CNT_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic rr_last;

  always_comb i_first = (rr_last == DPORT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_last <= DPORT;
    end else if (|gnt) begin
      rr_last <= gnt[DPORT];
    end
  end
`endif

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (req == 2'b11) begin
        if (i_first) gnt[IPORT] = 1'b1;
        else         gnt[DPORT] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

endmodule

// File: rtl/nanorv32_ram_arbiter.sv
// Shares one byte-write RAM between fetch and load/store ports; read data returns
// one cycle after grant. NANORV32_RAM_ARB_DPRIO_EN selects DPORT-priority arbitration.
module nanorv32_ram_arbiter
  import nanorv32_ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iport_req,
  input  logic [ADDR_WIDTH-1:0] iport_addr,
  output logic                  iport_gnt,
  output logic                  iport_rvalid,
  output logic [DATA_WIDTH-1:0] iport_rdata,
  input  logic                  dport_req,
  input  logic [ADDR_WIDTH-1:0] dport_addr,
  input  logic [NB_COL-1:0]     dport_we,
  input  logic [DATA_WIDTH-1:0] dport_wdata,
  output logic                  dport_gnt,
  output logic                  dport_rvalid,
  output logic [DATA_WIDTH-1:0] dport_rdata,
  output logic [NB_COL-1:0]     mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  logic [1:0] gnt;
  logic       sel_q;
  logic       win_sel;
  logic       rd_grant;
  logic       resp_valid;
  logic       resp_owner;

  nanorv32_rr_arb2 #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({dport_req, iport_req}),
    .gnt   (gnt)
  );

  assign iport_gnt = gnt[IPORT];
  assign dport_gnt = gnt[DPORT];

  // Idle cycles keep pointing at the last winner so the RAM address does not toggle.
  always_comb begin
    win_sel = sel_q;
    if (gnt[DPORT])      win_sel = DPORT;
    else if (gnt[IPORT]) win_sel = IPORT;
  end

  assign mem_addr = (win_sel == DPORT) ? dport_addr : iport_addr;
  assign mem_din  = dport_wdata;
  assign mem_we   = gnt[DPORT] ? dport_we : '0;
  assign rd_grant = gnt[IPORT] | (gnt[DPORT] & (dport_we == '0));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q      <= IPORT;
      resp_valid <= 1'b0;
      resp_owner <= IPORT;
    end else begin
      if (|gnt) sel_q <= win_sel;
      resp_valid <= rd_grant;
      if (rd_grant) resp_owner <= gnt[DPORT];
    end
  end

  assign iport_rvalid = resp_valid & (resp_owner == IPORT);
  assign dport_rvalid = resp_valid & (resp_owner == DPORT);
  assign iport_rdata  = iport_rvalid ? mem_dout : '0;
  assign dport_rdata  = dport_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_nanorv32_ram_arbiter.sv
// Directed bench for nanorv32_ram_arbiter with a registered byte-write RAM model.
module tb_nanorv32_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        iport_req;
  logic [11:0] iport_addr;
  logic        iport_gnt;
  logic        iport_rvalid;
  logic [31:0] iport_rdata;
  logic        dport_req;
  logic [11:0] dport_addr;
  logic [3:0]  dport_we;
  logic [31:0] dport_wdata;
  logic        dport_gnt;
  logic        dport_rvalid;
  logic [31:0] dport_rdata;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int n_pass  = 0;
  int n_total = 0;

  nanorv32_ram_arbiter #(.ADDR_WIDTH(12), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .iport_req    (iport_req),
    .iport_addr   (iport_addr),
    .iport_gnt    (iport_gnt),
    .iport_rvalid (iport_rvalid),
    .iport_rdata  (iport_rdata),
    .dport_req    (dport_req),
    .dport_addr   (dport_addr),
    .dport_we     (dport_we),
    .dport_wdata  (dport_wdata),
    .dport_gnt    (dport_gnt),
    .dport_rvalid (dport_rvalid),
    .dport_rdata  (dport_rdata),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ram_init(input logic [11:0] a);
    return (a == 12'h020) ? 32'h11223344 : {20'hC0DE0, a};
  endfunction

  logic [31:0] ram [0:4095];
  bit loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) ram[i] <= ram_init(12'(i));
      loaded <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
    end
    mem_dout <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

`ifdef NANORV32_RAM_ARB_DPRIO_EN
  localparam logic [5:0] PAT_I       = 6'b010000;
  localparam logic       RST_I_FIRST = 1'b0;
`else
  localparam logic [5:0] PAT_I       = 6'b010101;
  localparam logic       RST_I_FIRST = 1'b1;
`endif

  logic [5:0] pat;

  initial begin
    pat = PAT_I;
    rst_n = 1'b0; iport_req = 1'b0; iport_addr = '0;
    dport_req = 1'b0; dport_addr = '0; dport_we = '0; dport_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    iport_req = 1'b1; dport_req = 1'b1; dport_we = 4'hF;
    iport_addr = 12'h010; dport_addr = 12'h020;
    #4;
    check("rst_i_gnt", iport_gnt, 1'b0);
    check("rst_d_gnt", dport_gnt, 1'b0);
    check("rst_mem_we", mem_we, 4'h0);
    check("rst_i_rvalid", iport_rvalid, 1'b0);
    check("rst_d_rvalid", dport_rvalid, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1; iport_req = 1'b0; dport_req = 1'b0; dport_we = '0;
    #4;
    check("idle_i_rvalid", iport_rvalid, 1'b0);
    check("idle_d_rvalid", dport_rvalid, 1'b0);

    // fetch-only stream
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      iport_req = 1'b1; iport_addr = 12'h010;
      #4;
      check("f_i_gnt", iport_gnt, 1'b1);
      check("f_mem_addr", mem_addr, 12'h010);
      check("f_mem_we", mem_we, 4'h0);
      if (k > 0) begin
        check("f_i_rvalid", iport_rvalid, 1'b1);
        check("f_i_rdata", iport_rdata, 32'hC0DE0010);
      end else begin
        check("f_i_rvalid0", iport_rvalid, 1'b0);
      end
    end
    @(posedge clk); #1;
    iport_req = 1'b0;
    #4;
    check("f_last_gnt", iport_gnt, 1'b0);
    check("f_last_rvalid", iport_rvalid, 1'b1);
    check("f_last_rdata", iport_rdata, 32'hC0DE0010);
    check("f_hold_addr", mem_addr, 12'h010);
    @(posedge clk); #1; #4;
    check("f_end_rvalid", iport_rvalid, 1'b0);
    check("f_end_rdata", iport_rdata, 32'h0);

    // byte-enable write then read back
    @(posedge clk); #1;
    dport_req = 1'b1; dport_addr = 12'h020; dport_we = 4'b0101; dport_wdata = 32'hAABBCCDD;
    #4;
    check("w_d_gnt", dport_gnt, 1'b1);
    check("w_i_gnt", iport_gnt, 1'b0);
    check("w_mem_we", mem_we, 4'b0101);
    check("w_mem_addr", mem_addr, 12'h020);
    check("w_mem_din", mem_din, 32'hAABBCCDD);
    @(posedge clk); #1;
    dport_we = 4'b0000;
    #4;
    check("r_d_gnt", dport_gnt, 1'b1);
    check("w_no_rvalid", dport_rvalid, 1'b0);
    check("r_mem_we", mem_we, 4'h0);
    @(posedge clk); #1;
    dport_req = 1'b0;
    #4;
    check("r_d_rvalid", dport_rvalid, 1'b1);
    check("r_d_rdata", dport_rdata, 32'h11BB33DD);
    check("r_i_rvalid", iport_rvalid, 1'b0);
    check("r_hold_addr", mem_addr, 12'h020);
    @(posedge clk); #1; #4;
    check("r_end_rvalid", dport_rvalid, 1'b0);

    // continuous conflict
    iport_addr = 12'h010; dport_addr = 12'h030; dport_we = 4'h0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      iport_req = 1'b1; dport_req = 1'b1;
      #4;
      check("c_i_gnt", iport_gnt, pat[k]);
      check("c_d_gnt", dport_gnt, !pat[k]);
      if (k > 0) begin
        check("c_i_rvalid", iport_rvalid, pat[k-1]);
        check("c_d_rvalid", dport_rvalid, !pat[k-1]);
        check("c_i_rdata", iport_rdata, pat[k-1] ? 32'hC0DE0010 : 32'h0);
        check("c_d_rdata", dport_rdata, pat[k-1] ? 32'h0 : 32'hC0DE0030);
      end
    end
    @(posedge clk); #1;
    iport_req = 1'b0; dport_req = 1'b0;
    #4;
    check("c_tail_i_rvalid", iport_rvalid, pat[5]);
    check("c_tail_d_rvalid", dport_rvalid, !pat[5]);

    // reset right after a granted read
    @(posedge clk); #1;
    iport_req = 1'b1; iport_addr = 12'h010;
    #4;
    check("mr_i_gnt", iport_gnt, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0; dport_req = 1'b1; dport_we = 4'hF; dport_addr = 12'h060;
    dport_wdata = 32'h12345678;
    #4;
    check("mr_i_gnt_rst", iport_gnt, 1'b0);
    check("mr_d_gnt_rst", dport_gnt, 1'b0);
    check("mr_mem_we_rst", mem_we, 4'h0);
    @(posedge clk); #1; #4;
    check("mr_i_rvalid", iport_rvalid, 1'b0);
    check("mr_d_rvalid", dport_rvalid, 1'b0);
    check("mr_mem_we_rst2", mem_we, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; dport_we = 4'h0; dport_addr = 12'h030;
    #4;
    check("mr_first_i_gnt", iport_gnt, RST_I_FIRST);
    check("mr_first_d_gnt", dport_gnt, !RST_I_FIRST);
    check("mr_no_stale_rvalid", iport_rvalid | dport_rvalid, 1'b0);
    @(posedge clk); #1;
    iport_req = 1'b0; dport_req = 1'b0;
    #4;
    check("mr_post_i_rvalid", iport_rvalid, RST_I_FIRST);
    check("mr_post_d_rvalid", dport_rvalid, !RST_I_FIRST);

`ifndef NANORV32_RAM_ARB_DPRIO_EN
    // DPORT withdraws a losing write
    @(posedge clk); #1;
    dport_req = 1'b1; dport_addr = 12'h040; dport_we = 4'h0;
    #4;
    check("dr_d_gnt", dport_gnt, 1'b1);
    @(posedge clk); #1;
    iport_req = 1'b1; iport_addr = 12'h010;
    dport_addr = 12'h050; dport_we = 4'hF; dport_wdata = 32'hFFFFFFFF;
    #4;
    check("dr_i_wins", iport_gnt, 1'b1);
    check("dr_d_loses", dport_gnt, 1'b0);
    check("dr_mem_we", mem_we, 4'h0);
    check("dr_d_rdata", dport_rdata, 32'hC0DE0040);
    @(posedge clk); #1;
    iport_req = 1'b0; dport_req = 1'b0;
    #4;
    check("dr_no_d_rvalid", dport_rvalid, 1'b0);
    check("dr_i_rvalid", iport_rvalid, 1'b1);
    check("dr_mem_we2", mem_we, 4'h0);
    @(posedge clk); #1;
    dport_req = 1'b1; dport_we = 4'h0; dport_addr = 12'h050;
    #4;
    check("dr_rd_gnt", dport_gnt, 1'b1);
    @(posedge clk); #1;
    dport_req = 1'b0;
    #4;
    check("dr_unwritten", dport_rdata, 32'hC0DE0050);
`endif

    // write presented during reset must not reach the RAM
    @(posedge clk); #1;
    dport_req = 1'b1; dport_we = 4'h0; dport_addr = 12'h060;
    @(posedge clk); #1;
    dport_req = 1'b0;
    #4;
    check("rst_wr_blocked", dport_rdata, 32'hC0DE0060);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
